// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcodes,
// funct fields, ALU controls, ALUOp and the per-state control bundle.
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH   = 4'd0;
  localparam state_t S_DECODE  = 4'd1;
  localparam state_t S_MEMADR  = 4'd2;
  localparam state_t S_MEMRD   = 4'd3;
  localparam state_t S_MEMWB   = 4'd4;
  localparam state_t S_MEMWR   = 4'd5;
  localparam state_t S_EXECUTE = 4'd6;
  localparam state_t S_ALUWB   = 4'd7;
  localparam state_t S_BRANCH  = 4'd8;
  localparam state_t S_ADDIEX  = 4'd9;
  localparam state_t S_ADDIWB  = 4'd10;
  localparam state_t S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // All-zero bundle: no writes, FETCH-style selects, ALU add.
  localparam ctrl_t CTRL_NONE = '0;

  // Unknown funct codes fall back to add so the R-type still writes back.
  function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
    logic [2:0] res;
    case (funct)
      FN_ADD:  res = ALU_ADD;
      FN_SUB:  res = ALU_SUB;
      FN_AND:  res = ALU_AND;
      FN_OR:   res = ALU_OR;
      FN_SLT:  res = ALU_SLT;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's ALUOp and the instruction funct field to the
// 3-bit ALU control.
module aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // ALUOp selects a fixed operation or defers to the funct field.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD:   alucontrol = ALU_ADD;
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = funct_to_alu(funct);
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath with memory-ready stalls.
// Optional macro MC_BNE_EN adds bne (opcode 000101) through the BRANCH state.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_t     state_r;
  state_t     next_state_s;
  ctrl_t      ctrl_s;
  logic       branch_take_s;

  // State register; reset drops straight back to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; only the three memory states look at mem_ready.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:   next_state_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_EXECUTE;
          OP_BEQ:       next_state_s = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       next_state_s = S_BRANCH;
`endif
          OP_ADDI:      next_state_s = S_ADDIEX;
          OP_J:         next_state_s = S_JUMP;
          default:      next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR:  next_state_s = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next_state_s = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   next_state_s = S_FETCH;
      S_MEMWR:   next_state_s = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: next_state_s = S_ALUWB;
      S_ALUWB:   next_state_s = S_FETCH;
      S_BRANCH:  next_state_s = S_FETCH;
      S_ADDIEX:  next_state_s = S_ADDIWB;
      S_ADDIWB:  next_state_s = S_FETCH;
      S_JUMP:    next_state_s = S_FETCH;
      default:   next_state_s = S_FETCH;
    endcase
  end

  // Branch condition; bne inverts the zero flag.
  always_comb begin
    branch_take_s = 1'b0;
    if (op == OP_BEQ) begin
      branch_take_s = zero;
    end
`ifdef MC_BNE_EN
    else if (op == OP_BNE) begin
      branch_take_s = ~zero;
    end
`endif
    else begin
      branch_take_s = 1'b0;
    end
  end

  // Moore output decode; FETCH's enables follow mem_ready so a stalled fetch
  // neither loads IR nor advances PC.
  always_comb begin
    ctrl_s = CTRL_NONE;
    case (state_r)
      S_FETCH: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.alusrcb = 2'b01;
        ctrl_s.irwrite = mem_ready;
        ctrl_s.pcen    = mem_ready;
      end
      S_DECODE: begin
        ctrl_s.alusrcb = 2'b11;
      end
      S_MEMADR: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_s.memtoreg = 1'b1;
        ctrl_s.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl_s.mem_req  = 1'b1;
        ctrl_s.iord     = 1'b1;
        ctrl_s.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = 2'b00;
        ctrl_s.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_s.regdst   = 1'b1;
        ctrl_s.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.aluop   = ALUOP_SUB;
        ctrl_s.pcsrc   = 2'b01;
        ctrl_s.pcen    = branch_take_s;
      end
      S_ADDIEX: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        ctrl_s.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl_s.pcsrc = 2'b10;
        ctrl_s.pcen  = 1'b1;
      end
      default: begin
        ctrl_s = CTRL_NONE;
      end
    endcase
  end

  aludec u_aludec (
    .aluop      (ctrl_s.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // Reset masks every write enable and the memory request immediately.
  assign mem_req  = ctrl_s.mem_req  & ~rst;
  assign pcen     = ctrl_s.pcen     & ~rst;
  assign irwrite  = ctrl_s.irwrite  & ~rst;
  assign regwrite = ctrl_s.regwrite & ~rst;
  assign memwrite = ctrl_s.memwrite & ~rst;
  assign iord     = ctrl_s.iord;
  assign regdst   = ctrl_s.regdst;
  assign memtoreg = ctrl_s.memtoreg;
  assign alusrca  = ctrl_s.alusrca;
  assign alusrcb  = ctrl_s.alusrcb;
  assign pcsrc    = ctrl_s.pcsrc;
  assign state    = state_r;

endmodule
